dmem_responder: RTL and testbench



---
 rtl/dmem_pkg.sv | 14 +
 rtl/dmem_responder_if.sv | 29 ++
 rtl/dmem_sram_bank.sv | 34 +++
 rtl/dmem_responder.sv | 110 +++++++++++
 tb/tb_dmem_responder.sv | 321 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder.
//   state_t   : responder FSM states (IDLE / BUSY / RESP)
//   LAT_CNT_W : width of the acceptance-to-response latency counter
package dmem_pkg;

    localparam int unsigned LAT_CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/dmem_responder_if.sv
// Load/store request + read-response bundle between the EX/MEM initiator
// and the data-memory responder.
//   Address, MEMRead, MEMWrite, Write_data, Write_strb : request (master -> slave)
//   Mem_Req_Ready                                      : request accept (slave -> master)
//   Read_data, Read_data_Valid                         : response (slave -> master)
//   Read_data_Ready                                    : response accept (master -> slave)
interface dmem_responder_if;

    logic [31:0] Address;
    logic        MEMRead;
    logic        MEMWrite;
    logic [31:0] Write_data;
    logic [3:0]  Write_strb;
    logic        Mem_Req_Ready;
    logic [31:0] Read_data;
    logic        Read_data_Valid;
    logic        Read_data_Ready;

    modport master (
        output Address, MEMRead, MEMWrite, Write_data, Write_strb, Read_data_Ready,
        input  Mem_Req_Ready, Read_data, Read_data_Valid
    );

    modport slave (
        input  Address, MEMRead, MEMWrite, Write_data, Write_strb, Read_data_Ready,
        output Mem_Req_Ready, Read_data, Read_data_Valid
    );

endinterface

// File: rtl/dmem_sram_bank.sv
// Single-port 2^ADDR_W x 32 word array with per-byte write enables and a
// synchronous read register that only updates when re is high, so the last
// read word stays available until the next read.
//   clk   : clock
//   we    : byte write enables (bit i writes wdata[8i+7:8i])
//   re    : read enable, captures mem[addr] into rdata
//   addr  : word index
//   wdata : lane-aligned write data
//   rdata : captured read word
module dmem_sram_bank #(
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clk,
    input  logic [3:0]        we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    logic [31:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        for (int unsigned b = 0; b < 4; b++) begin
            if (we[b]) begin
                mem[addr][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
        if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: slave end of the pipeline load/store handshake.
// Accepts one request at a time, commits byte-strobed writes at the
// acceptance edge, and returns read data on a valid/ready channel LATENCY
// cycles after acceptance. Keeps completed-read / committed-write counters.
//   clk, rst : clock, synchronous active-high reset
//   bus      : request/response bundle (slave modport)
//   rd_cnt   : completed read responses (wraps)
//   wr_cnt   : committed writes (wraps)
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned ADDR_W  = 10,
    parameter int unsigned LATENCY = 2
) (
    input  logic            clk,
    input  logic            rst,
    dmem_responder_if.slave bus,
    output logic [31:0]     rd_cnt,
    output logic [31:0]     wr_cnt
);

    localparam logic [LAT_CNT_W-1:0] LAT_LOAD = LAT_CNT_W'(LATENCY - 1);

    state_t               state;
    logic [LAT_CNT_W-1:0] lat_cnt;
    logic                 pend_read;

    logic                 accept;
    logic [ADDR_W-1:0]    idx;
    logic [3:0]           sram_we;
    logic                 sram_re;
    logic [31:0]          sram_rdata;
    logic                 unused_addr_bits;

    // Upper address bits wrap; the byte offset is ignored.
    assign idx              = bus.Address[ADDR_W+1:2];
    assign unused_addr_bits = ^{bus.Address[31:ADDR_W+2], bus.Address[1:0]};

    assign accept  = bus.Mem_Req_Ready & (bus.MEMRead | bus.MEMWrite);
    // Write wins when both request lines are high; such a request never reads.
    assign sram_we = (accept & bus.MEMWrite) ? bus.Write_strb : '0;
    assign sram_re = accept & bus.MEMRead & ~bus.MEMWrite;

    dmem_sram_bank #(
        .ADDR_W (ADDR_W)
    ) u_bank (
        .clk   (clk),
        .we    (sram_we),
        .re    (sram_re),
        .addr  (idx),
        .wdata (bus.Write_data),
        .rdata (sram_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state               <= IDLE;
            lat_cnt             <= '0;
            pend_read           <= 1'b0;
            bus.Mem_Req_Ready   <= 1'b0;
            bus.Read_data_Valid <= 1'b0;
            bus.Read_data       <= '0;
            rd_cnt              <= '0;
            wr_cnt              <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        bus.Mem_Req_Ready <= 1'b0;
                        lat_cnt           <= LAT_LOAD;
                        pend_read         <= ~bus.MEMWrite;
                        state             <= BUSY;
                        if (bus.MEMWrite) begin
                            wr_cnt <= wr_cnt + 32'd1;
                        end
                    end else begin
                        // Also raises ready on the first edge after reset.
                        bus.Mem_Req_Ready <= 1'b1;
                    end
                end
                BUSY: begin
                    if (lat_cnt == '0) begin
                        if (pend_read) begin
                            bus.Read_data       <= sram_rdata;
                            bus.Read_data_Valid <= 1'b1;
                            state               <= RESP;
                        end else begin
                            bus.Mem_Req_Ready <= 1'b1;
                            state             <= IDLE;
                        end
                    end else begin
                        lat_cnt <= lat_cnt - 1'b1;
                    end
                end
                RESP: begin
                    if (bus.Read_data_Ready) begin
                        bus.Read_data_Valid <= 1'b0;
                        bus.Mem_Req_Ready   <= 1'b1;
                        rd_cnt              <= rd_cnt + 32'd1;
                        state               <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: DUT0 uses defaults (ADDR_W=10, LATENCY=2),
// DUT1 uses ADDR_W=4, LATENCY=1. A timestamp-based reference model predicts
// every output each cycle; directed tests add literal expectations.
module tb_dmem_responder;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [31:0] req_addr [2];
    logic [31:0] req_data [2];
    logic [3:0]  req_strb [2];
    logic        req_rd   [2];
    logic        req_wr   [2];
    logic        rsp_rdy  [2];

    logic        o_ready [2];
    logic        o_valid [2];
    logic [31:0] o_data  [2];
    logic [31:0] o_rd    [2];
    logic [31:0] o_wr    [2];

    int checks = 0;
    int errors = 0;

    dmem_responder_if if0 ();
    dmem_responder_if if1 ();

    assign if0.Address         = req_addr[0];
    assign if0.MEMRead         = req_rd[0];
    assign if0.MEMWrite        = req_wr[0];
    assign if0.Write_data      = req_data[0];
    assign if0.Write_strb      = req_strb[0];
    assign if0.Read_data_Ready = rsp_rdy[0];
    assign o_ready[0]          = if0.Mem_Req_Ready;
    assign o_valid[0]          = if0.Read_data_Valid;
    assign o_data[0]           = if0.Read_data;

    assign if1.Address         = req_addr[1];
    assign if1.MEMRead         = req_rd[1];
    assign if1.MEMWrite        = req_wr[1];
    assign if1.Write_data      = req_data[1];
    assign if1.Write_strb      = req_strb[1];
    assign if1.Read_data_Ready = rsp_rdy[1];
    assign o_ready[1]          = if1.Mem_Req_Ready;
    assign o_valid[1]          = if1.Read_data_Valid;
    assign o_data[1]           = if1.Read_data;

    dmem_responder dut0 (
        .clk    (clk),
        .rst    (rst),
        .bus    (if0.slave),
        .rd_cnt (o_rd[0]),
        .wr_cnt (o_wr[0])
    );

    dmem_responder #(
        .ADDR_W  (4),
        .LATENCY (1)
    ) dut1 (
        .clk    (clk),
        .rst    (rst),
        .bus    (if1.slave),
        .rd_cnt (o_rd[1]),
        .wr_cnt (o_wr[1])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Per instance: outputs as predicted, plus the edge number at which a
    // pending write frees the port (free_at) or a pending read responds (resp_at).
    int          cyc = 0;
    bit          live = 0;
    logic        m_ready [2];
    logic        m_valid [2];
    logic [31:0] m_data  [2];
    logic [31:0] m_rd    [2];
    logic [31:0] m_wr    [2];
    logic [31:0] m_cap   [2];
    int          free_at [2];
    int          resp_at [2];
    logic [31:0] m_mem [int];

    task automatic model_step(input int k);
        int lat;
        int key;
        logic [31:0] w;
        lat = (k == 0) ? 2 : 1;
        key = k * 100000 + ((k == 0) ? int'(req_addr[k] >> 2) % 1024 : int'(req_addr[k] >> 2) % 16);
        if (rst) begin
            m_ready[k] = 1'b0;
            m_valid[k] = 1'b0;
            m_data[k]  = '0;
            m_rd[k]    = '0;
            m_wr[k]    = '0;
            free_at[k] = -1;
            resp_at[k] = -1;
        end else begin
            if (m_valid[k]) begin
                if (rsp_rdy[k]) begin
                    m_valid[k] = 1'b0;
                    m_rd[k]    = m_rd[k] + 1;
                    m_ready[k] = 1'b1;
                end
            end else if (m_ready[k] && (req_rd[k] || req_wr[k])) begin
                m_ready[k] = 1'b0;
                if (req_wr[k]) begin
                    w = m_mem.exists(key) ? m_mem[key] : '0;
                    for (int b = 0; b < 4; b++)
                        if (req_strb[k][b]) w[8*b +: 8] = req_data[k][8*b +: 8];
                    m_mem[key] = w;
                    m_wr[k]    = m_wr[k] + 1;
                    free_at[k] = cyc + lat;
                end else begin
                    m_cap[k]   = m_mem.exists(key) ? m_mem[key] : '0;
                    resp_at[k] = cyc + lat;
                end
            end else if (!m_ready[k] && free_at[k] < 0 && resp_at[k] < 0) begin
                m_ready[k] = 1'b1;
            end
            if (cyc == free_at[k]) begin
                m_ready[k] = 1'b1;
                free_at[k] = -1;
            end
            if (cyc == resp_at[k]) begin
                m_valid[k] = 1'b1;
                m_data[k]  = m_cap[k];
                resp_at[k] = -1;
            end
        end
    endtask

    always @(posedge clk) begin
        cyc++;
        if (rst) live = 1;
        if (live) begin
            model_step(0);
            model_step(1);
        end
    end

    always @(negedge clk) begin
        if (live) begin
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("dut%0d_ready", k), o_ready[k], m_ready[k]);
                chk($sformatf("dut%0d_valid", k), o_valid[k], m_valid[k]);
                chk($sformatf("dut%0d_data", k),  o_data[k],  m_data[k]);
                chk($sformatf("dut%0d_rd_cnt", k), o_rd[k],   m_rd[k]);
                chk($sformatf("dut%0d_wr_cnt", k), o_wr[k],   m_wr[k]);
            end
        end
    end

    // ---------------- stimulus ----------------
    // Called at a negedge; returns at the negedge just after the accepting edge.
    task automatic issue(input int k, input logic [31:0] a, input logic r, input logic w,
                         input logic [31:0] d, input logic [3:0] s);
        bit done = 0;
        req_addr[k] = a;
        req_rd[k]   = r;
        req_wr[k]   = w;
        req_data[k] = d;
        req_strb[k] = s;
        for (int i = 0; i < 64 && !done; i++) begin
            if (o_ready[k] === 1'b1) done = 1;
            @(negedge clk);
        end
        req_rd[k] = 1'b0;
        req_wr[k] = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout dut%0d: got no ready expected ready within 64 cycles", k);
        end
    endtask

    task automatic wr(input int k, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        issue(k, a, 1'b0, 1'b1, d, s);
    endtask

    task automatic wait_valid(input int k, output bit got);
        got = 0;
        for (int i = 0; i < 64 && !got; i++) begin
            if (o_valid[k] === 1'b1) got = 1;
            else @(negedge clk);
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL valid_timeout dut%0d: got no valid expected valid within 64 cycles", k);
        end
    endtask

    task automatic read_expect(input int k, input logic [31:0] a, input logic [31:0] exp,
                               input string name);
        bit got;
        issue(k, a, 1'b1, 1'b0, '0, '0);
        wait_valid(k, got);
        if (got) chk(name, o_data[k], exp);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200us");
        $fatal(1, "watchdog");
    end

    initial begin
        bit got;
        for (int k = 0; k < 2; k++) begin
            req_addr[k] = '0;
            req_data[k] = '0;
            req_strb[k] = '0;
            req_rd[k]   = 1'b0;
            req_wr[k]   = 1'b0;
            rsp_rdy[k]  = 1'b1;
        end
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_ready", o_ready[0], 32'd0);
        chk("reset_valid", o_valid[0], 32'd0);
        chk("reset_data",  o_data[0],  32'd0);
        chk("reset_rd_cnt", o_rd[0],   32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", o_ready[0], 32'd1);

        // write then read, LATENCY=2
        wr(0, 32'h40, 32'hDEADBEEF, 4'hF);
        chk("t1_ready_T0", o_ready[0], 32'd0);
        @(negedge clk);
        @(negedge clk);
        chk("t1_ready_T2", o_ready[0], 32'd1);
        issue(0, 32'h40, 1'b1, 1'b0, '0, '0);
        @(negedge clk);
        @(negedge clk);
        chk("t1_valid_T5", o_valid[0], 32'd1);
        chk("t1_data_T5",  o_data[0],  32'hDEADBEEF);
        @(negedge clk);
        chk("t1_rd_cnt", o_rd[0], 32'd1);
        chk("t1_wr_cnt", o_wr[0], 32'd1);

        // partial and zero strobes
        wr(0, 32'h40, 32'h11223344, 4'hF);
        wr(0, 32'h40, 32'h0000AA00, 4'b0010);
        read_expect(0, 32'h40, 32'h1122AA44, "t2_partial");
        wr(0, 32'h40, 32'hFFFFFFFF, 4'b0000);
        read_expect(0, 32'h40, 32'h1122AA44, "t2_zero_strb");
        chk("t2_wr_cnt", o_wr[0], 32'd4);
        chk("t2_rd_cnt", o_rd[0], 32'd3);

        // response backpressure with an ignored write
        wr(0, 32'h80, 32'hCAFEF00D, 4'hF);
        rsp_rdy[0] = 1'b0;
        issue(0, 32'h80, 1'b1, 1'b0, '0, '0);
        wait_valid(0, got);
        req_addr[0] = 32'h80;
        req_data[0] = 32'h0;
        req_strb[0] = 4'hF;
        req_wr[0]   = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("t3_hold_valid", o_valid[0], 32'd1);
            chk("t3_hold_data",  o_data[0],  32'hCAFEF00D);
            chk("t3_hold_ready", o_ready[0], 32'd0);
            chk("t3_hold_rd_cnt", o_rd[0],   32'd3);
            @(negedge clk);
        end
        req_wr[0]  = 1'b0;
        rsp_rdy[0] = 1'b1;
        @(negedge clk);
        chk("t3_rd_cnt_at_ready", o_rd[0], 32'd4);
        chk("t3_valid_dropped", o_valid[0], 32'd0);
        read_expect(0, 32'h80, 32'hCAFEF00D, "t3_no_write_while_busy");

        // simultaneous read+write
        issue(0, 32'h8, 1'b1, 1'b1, 32'h77, 4'hF);
        for (int i = 0; i < 5; i++) begin
            chk("t4_no_valid", o_valid[0], 32'd0);
            @(negedge clk);
        end
        chk("t4_rd_cnt", o_rd[0], 32'd5);
        read_expect(0, 32'h8, 32'h77, "t4_written");
        chk("t4_wr_cnt", o_wr[0], 32'd6);

        // wrap with ADDR_W=4, LATENCY=1
        wr(1, 32'h44, 32'h5, 4'hF);
        issue(1, 32'h04, 1'b1, 1'b0, '0, '0);
        @(negedge clk);
        chk("t6_valid_lat1", o_valid[1], 32'd1);
        chk("t6_wrap_data",  o_data[1],  32'h5);
        @(negedge clk);

        // reset during BUSY of a read
        issue(0, 32'h40, 1'b1, 1'b0, '0, '0);
        rst = 1'b1;
        @(negedge clk);
        chk("t5_valid", o_valid[0], 32'd0);
        chk("t5_ready", o_ready[0], 32'd0);
        chk("t5_rd_cnt", o_rd[0], 32'd0);
        chk("t5_wr_cnt", o_wr[0], 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("t5_ready_after", o_ready[0], 32'd1);
        for (int i = 0; i < 6; i++) begin
            chk("t5_no_stale", o_valid[0], 32'd0);
            @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
